// File: rtl/fb_pkg.sv
// Shared defaults, FSM states and FIFO entry layout for the framebuffer pixel writer.
package fb_pkg;

   localparam int CORDW_DEF = 11;
   localparam int H_RES_DEF = 640;
   localparam int V_RES_DEF = 480;
   localparam int COLRW_DEF = 4;
   localparam int ADDRW_DEF = 19;

   typedef enum logic [1:0] {
      DRAW    = 2'd0,
      FLUSH   = 2'd1,
      WAIT_VS = 2'd2,
      SWAP    = 2'd3
   } fbw_state_t;

   typedef struct packed {
      logic [ADDRW_DEF-1:0] addr;
      logic [COLRW_DEF-1:0] colr;
   } fb_entry_t;

endpackage

// File: rtl/fb_fifo.sv
// Synchronous show-ahead FIFO: head entry is visible on o_data whenever o_empty is low.
module fb_fifo #(
   parameter int W     = 23,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     i_push,
   input  logic [W-1:0]             i_data,
   input  logic                     i_pop,
   output logic [W-1:0]             o_data,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_pop;

   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rd_ptr];
   assign w_pop   = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({i_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/fb_pixel_writer.sv
// Clips the signed pixel stream, queues linear addresses and writes them into the
// back buffer of a double-buffered framebuffer, swapping buffers at vsync after a frame.
module fb_pixel_writer
   import fb_pkg::*;
#(
   parameter int CORDW      = CORDW_DEF,
   parameter int H_RES      = H_RES_DEF,
   parameter int V_RES      = V_RES_DEF,
   parameter int COLRW      = COLRW_DEF,
   parameter int ADDRW      = ADDRW_DEF,
   parameter int FIFO_DEPTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             pix_valid,
   output logic             pix_ready,
   input  logic [CORDW-1:0] pix_x,
   input  logic [CORDW-1:0] pix_y,
   input  logic [COLRW-1:0] pix_colr,
   input  logic             frame_done,
   input  logic             vsync_start,
   output logic             mem_we,
   input  logic             mem_ready,
   output logic [ADDRW:0]   mem_addr,
   output logic [COLRW-1:0] mem_data,
   output logic             disp_buf,
   output logic             swap,
   output logic [15:0]      clipped_cnt,
   output logic             idle
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int EW = ADDRW + COLRW;

   if ((64'd1 << ADDRW) < 64'(H_RES) * 64'(V_RES)) begin : g_chk_addrw
      $error("ADDRW too small for H_RES*V_RES");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
      $error("FIFO_DEPTH must be a power of two >= 2");
   end
   if (H_RES >= (1 << (CORDW - 1)) || V_RES >= (1 << (CORDW - 1))) begin : g_chk_cord
      $error("H_RES/V_RES must fit the signed coordinate range");
   end

   localparam logic signed [CORDW-1:0] H_LIM = CORDW'(H_RES);
   localparam logic signed [CORDW-1:0] V_LIM = CORDW'(V_RES);

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   fbw_state_t r_state;
   fbw_state_t w_state_nxt;

   logic signed [CORDW-1:0] w_x_s;
   logic signed [CORDW-1:0] w_y_s;
   logic                    w_acc;
   logic                    w_on_scr;
   logic [ADDRW-1:0]        w_addr;
   logic                    w_vs_take;

   logic                    r_s1_vld_p1;
   logic [ADDRW-1:0]        r_s1_addr_p1;
   logic [COLRW-1:0]        r_s1_colr_p1;

   logic                    r_disp_buf;
   logic [15:0]             r_clip_cnt;

   logic [EW-1:0]           w_head;
   logic                    w_empty;
   logic [CW-1:0]           w_count;
   logic [CW:0]             w_occ;
   logic                    w_pop;

   assign w_x_s    = pix_x;
   assign w_y_s    = pix_y;
   assign w_on_scr = !w_x_s[CORDW-1] && (w_x_s < H_LIM) &&
                     !w_y_s[CORDW-1] && (w_y_s < V_LIM);
   assign w_addr   = ADDRW'(unsigned'(w_y_s)) * ADDRW'(H_RES) + ADDRW'(unsigned'(w_x_s));

   // Occupancy counts the S1 slot so an accepted pixel always has a FIFO entry waiting.
   assign w_occ     = {1'b0, w_count} + {{CW{1'b0}}, r_s1_vld_p1};
   assign pix_ready = rstn && (r_state == DRAW) && (w_occ < (CW+1)'(FIFO_DEPTH));
   assign w_acc     = pix_valid && pix_ready;
   assign w_vs_take = (r_state == WAIT_VS) && vsync_start;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         DRAW:    if (frame_done) w_state_nxt = FLUSH;
         FLUSH:   if (!r_s1_vld_p1 && w_empty) w_state_nxt = WAIT_VS;
         WAIT_VS: if (vsync_start) w_state_nxt = SWAP;
         SWAP:    w_state_nxt = DRAW;
         default: w_state_nxt = DRAW;
      endcase
   end

   // p0 -> p1: clip and address computation
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state     <= DRAW;
         r_s1_vld_p1 <= 1'b0;
         r_disp_buf  <= 1'b0;
         r_clip_cnt  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_s1_vld_p1 <= w_acc && w_on_scr;
         if (w_vs_take) begin
            r_disp_buf <= ~r_disp_buf;
            r_clip_cnt <= '0;
         end else if (w_acc && !w_on_scr) begin
            r_clip_cnt <= sat_inc16(r_clip_cnt);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_acc) begin
         r_s1_addr_p1 <= w_addr;
         r_s1_colr_p1 <= pix_colr;
      end
   end

   // p1 -> FIFO: push, memory side pops from the head
   assign w_pop = mem_we && mem_ready;

   fb_fifo #(
      .W     (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .i_push  (r_s1_vld_p1),
      .i_data  ({r_s1_addr_p1, r_s1_colr_p1}),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign mem_we      = !w_empty;
   assign mem_addr    = {~r_disp_buf, w_head[EW-1:COLRW]};
   assign mem_data    = w_head[COLRW-1:0];
   assign disp_buf    = r_disp_buf;
   assign swap        = (r_state == SWAP);
   assign clipped_cnt = r_clip_cnt;
   assign idle        = (r_state == DRAW) && !r_s1_vld_p1 && w_empty;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Scoreboard bench for fb_pixel_writer: stimulus queues expected writes, a negedge monitor checks them.
module tb_fb_pixel_writer;

   logic        clk = 1'b0;
   logic        rstn;
   logic        pix_valid;
   logic        pix_ready;
   logic [10:0] pix_x;
   logic [10:0] pix_y;
   logic [3:0]  pix_colr;
   logic        frame_done;
   logic        vsync_start;
   logic        mem_we;
   logic        mem_ready;
   logic [19:0] mem_addr;
   logic [3:0]  mem_data;
   logic        disp_buf;
   logic        swap;
   logic [15:0] clipped_cnt;
   logic        idle;

   int checks = 0;
   int errors = 0;
   int n_wr   = 0;
   int n_swap = 0;

   logic [23:0] exp_q[$];
   logic [23:0] exp_e;
   logic        hold_v = 1'b0;
   logic [23:0] hold_d;

   always #5 clk = ~clk;

   fb_pixel_writer dut (
      .clk         (clk),
      .rstn        (rstn),
      .pix_valid   (pix_valid),
      .pix_ready   (pix_ready),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .pix_colr    (pix_colr),
      .frame_done  (frame_done),
      .vsync_start (vsync_start),
      .mem_we      (mem_we),
      .mem_ready   (mem_ready),
      .mem_addr    (mem_addr),
      .mem_data    (mem_data),
      .disp_buf    (disp_buf),
      .swap        (swap),
      .clipped_cnt (clipped_cnt),
      .idle        (idle)
   );

   // Monitor: pops the scoreboard on every accepted write, checks held outputs under stall.
   always @(negedge clk) begin
      if (rstn === 1'b1 && mem_we === 1'b1 && mem_ready === 1'b1) begin
         n_wr++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr=%0h data=%0h", mem_addr, mem_data);
         end else begin
            exp_e = exp_q.pop_front();
            if ({mem_addr, mem_data} !== exp_e) begin
               errors++;
               $display("FAIL write_data got addr=%0h data=%0h expected addr=%0h data=%0h",
                        mem_addr, mem_data, exp_e[23:4], exp_e[3:0]);
            end
         end
      end
      if (hold_v && rstn === 1'b1 && mem_we === 1'b1) begin
         checks++;
         if ({mem_addr, mem_data} !== hold_d) begin
            errors++;
            $display("FAIL stall_hold got=%0h expected=%0h", {mem_addr, mem_data}, hold_d);
         end
      end
      hold_v = (rstn === 1'b1) && (mem_we === 1'b1) && (mem_ready === 1'b0);
      hold_d = {mem_addr, mem_data};
      if (swap === 1'b1) n_swap++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic send_pix(input int x, input int y, input logic [3:0] c,
                           input logic wr, input logic [19:0] ea);
      int n;
      pix_x     = 11'(x);
      pix_y     = 11'(y);
      pix_colr  = c;
      pix_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (pix_ready === 1'b1) begin
            if (wr) exp_q.push_back({ea, c});
            break;
         end
         n++;
         if (n > 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout x=%0d y=%0d", x, y);
            break;
         end
      end
      @(posedge clk); #1;
      pix_valid = 1'b0;
   endtask

   task automatic wait_empty(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || mem_we !== 1'b0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(name, 32'((exp_q.size() == 0) && (mem_we === 1'b0)), 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      int acc;
      int k;
      int n;
      rstn = 1'b0; pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_colr = '0;
      frame_done = 1'b0; vsync_start = 1'b0; mem_ready = 1'b1;

      // 1. reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_swap", swap, 0);
      chk("rst_disp_buf", disp_buf, 0);
      chk("rst_clipped", clipped_cnt, 0);
      chk("rst_pix_ready", pix_ready, 0);
      @(posedge clk); #1;
      rstn = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", pix_ready, 1);
      chk("post_rst_idle", idle, 1);
      @(posedge clk); #1;

      // 2. single pixel, latency and one-cycle write
      send_pix(10, 2, 4'd5, 1'b1, 20'h80000 | 20'd1290);
      @(negedge clk); chk("lat_cycle1_we", mem_we, 0);
      @(negedge clk); chk("lat_cycle2_we", mem_we, 1);
      @(negedge clk); chk("lat_cycle3_we", mem_we, 0);
      wait_empty("single_drain");

      // 3. clipping
      send_pix(-1,  0,   4'd1, 1'b0, 20'h0);
      send_pix(640, 0,   4'd2, 1'b0, 20'h0);
      send_pix(0,   480, 4'd3, 1'b0, 20'h0);
      send_pix(639, 479, 4'd7, 1'b1, 20'h80000 | 20'd307199);
      wait_empty("clip_drain");
      chk("clip_count", clipped_cnt, 3);
      chk("clip_writes", n_wr, 2);

      // 4. backpressure: 12 pixels at (100+k, 3) -> addr 2020+k
      mem_ready = 1'b0;
      acc = 0; k = 0;
      pix_x = 11'(100); pix_y = 11'(3); pix_colr = 4'd0; pix_valid = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (pix_ready === 1'b1) begin
            exp_q.push_back({20'h80000 | 20'(2020 + k), 4'(k)});
            k++; acc++;
         end
         @(posedge clk); #1;
         pix_x = 11'(100 + k); pix_colr = 4'(k);
      end
      chk("bp_accepted", acc, 8);
      @(negedge clk);
      chk("bp_ready_low", pix_ready, 0);
      chk("bp_writes_held", n_wr, 2);
      @(posedge clk); #1;
      mem_ready = 1'b1;
      n = 0;
      while (k < 12 && n < 200) begin
         @(negedge clk);
         if (pix_ready === 1'b1) begin
            exp_q.push_back({20'h80000 | 20'(2020 + k), 4'(k)});
            k++;
         end
         @(posedge clk); #1;
         pix_x = 11'(100 + k); pix_colr = 4'(k);
         n++;
      end
      pix_valid = 1'b0;
      chk("bp_all_accepted", k, 12);
      wait_empty("bp_drain");
      chk("bp_writes", n_wr, 14);

      // 5. swap: vsync during FLUSH ignored, next vsync swaps
      mem_ready = 1'b0;
      send_pix(20, 10, 4'd1, 1'b1, 20'h80000 | 20'd6420);
      send_pix(21, 10, 4'd2, 1'b1, 20'h80000 | 20'd6421);
      send_pix(22, 10, 4'd3, 1'b1, 20'h80000 | 20'd6422);
      frame_done = 1'b1;
      @(posedge clk); #1;
      frame_done  = 1'b0;
      vsync_start = 1'b1;
      @(posedge clk); #1;
      vsync_start = 1'b0;
      @(negedge clk);
      chk("flush_vs_no_swap", swap, 0);
      chk("flush_disp_buf", disp_buf, 0);
      chk("flush_ready_low", pix_ready, 0);
      @(posedge clk); #1;
      mem_ready = 1'b1;
      wait_empty("swap_drain");
      repeat (2) @(posedge clk);
      #1;
      chk("no_early_swap", n_swap, 0);
      chk("pre_swap_clipped", clipped_cnt, 3);
      vsync_start = 1'b1;
      @(posedge clk); #1;
      vsync_start = 1'b0;
      @(negedge clk);
      chk("swap_pulse", swap, 1);
      chk("swap_disp_buf", disp_buf, 1);
      chk("swap_clipped_clr", clipped_cnt, 0);
      @(negedge clk);
      chk("swap_one_cycle", swap, 0);
      chk("swap_ready_back", pix_ready, 1);
      chk("swap_count", n_swap, 1);
      @(posedge clk); #1;
      send_pix(5, 0, 4'd9, 1'b1, 20'h00005);
      wait_empty("post_swap_drain");

      // 6. reset mid-frame with 5 queued writes
      mem_ready = 1'b0;
      for (int i = 0; i < 5; i++) send_pix(30 + i, 1, 4'(i + 1), 1'b0, 20'h0);
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("mid_we_before", mem_we, 1);
      n = n_wr;
      @(posedge clk); #1;
      rstn = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_we", mem_we, 0);
      chk("mid_rst_ready", pix_ready, 0);
      @(posedge clk); #1;
      mem_ready = 1'b1;
      @(posedge clk); #1;
      rstn = 1'b1;
      repeat (10) @(negedge clk);
      chk("mid_no_stale", n_wr, n);
      chk("mid_disp_buf", disp_buf, 0);
      @(posedge clk); #1;
      send_pix(1, 1, 4'd6, 1'b1, 20'h80000 | 20'd641);
      wait_empty("final_drain");
      chk("final_swaps", n_swap, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

endmodule
